// File: rtl/icetap_pkg.sv
// Shared definitions for the icetap capture core: FSM encodings and
// parameter limits.
package icetap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ARMED     = 2'd1,
      ST_TRIGGERED = 2'd2,
      ST_DONE      = 2'd3
   } cap_state_e;

   localparam int MAX_STAGES  = 8;
   localparam int MAX_SIGNALS = 64;

   // Width of a stage index; a single-stage trigger still needs one bit.
   function automatic int stg_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/icetap_capture_ram.sv
// Simple dual-port capture buffer: one write port and one registered read
// port. A read and a write of the same address return the old word.
module icetap_capture_ram #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read port (one cycle latency, read-before-write).
   always_ff @(posedge clk) begin
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/icetap_seq_capture.sv
// icetap capture core: multi-stage sequential trigger, change-qualified
// circular recording and a programmable post-trigger sample count.
// Valid/ready is not used here: start and abort are single-cycle command
// pulses that are acted on in the cycle they are high (abort wins a tie).
module icetap_seq_capture
   import icetap_pkg::*;
#(
   parameter  int NR_SIGNALS   = 16,
   parameter  int RECORD_DEPTH = 256,
   parameter  int NR_STAGES    = 4,
   localparam int ADDR_BITS    = $clog2(RECORD_DEPTH),
   localparam int STG_BITS     = stg_bits(NR_STAGES)
) (
   input  logic                            src_clk,
   input  logic                            src_reset,
   input  logic [NR_SIGNALS-1:0]           signals_in,
   input  logic                            start,
   input  logic                            abort,
   input  logic [STG_BITS-1:0]             stages_used,
   input  logic [NR_STAGES*NR_SIGNALS-1:0] stage_mask,
   input  logic [NR_STAGES*NR_SIGNALS-1:0] stage_value,
   input  logic [NR_STAGES*NR_SIGNALS-1:0] stage_edge,
   input  logic [NR_SIGNALS-1:0]           store_mask,
   input  logic                            store_always,
   input  logic [ADDR_BITS-1:0]            post_trigger_count,
   output logic [1:0]                      state,
   output logic [STG_BITS-1:0]             cur_stage,
   output logic                            triggered,
   output logic                            wrapped,
   output logic [ADDR_BITS-1:0]            start_addr,
   output logic [ADDR_BITS-1:0]            trigger_addr,
   output logic [ADDR_BITS-1:0]            stop_addr,
   input  logic [ADDR_BITS-1:0]            read_addr,
   output logic [NR_SIGNALS-1:0]           read_data
);

   cap_state_e            state_q, state_d;
   logic [STG_BITS-1:0]   cur_stage_q, cur_stage_d;
   logic                  triggered_q, triggered_d;
   logic                  wrapped_q, wrapped_d;
   logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS-1:0]  remain_q, remain_d;
   logic [ADDR_BITS-1:0]  start_addr_q, start_addr_d;
   logic [ADDR_BITS-1:0]  trigger_addr_q, trigger_addr_d;
   logic [ADDR_BITS-1:0]  stop_addr_q, stop_addr_d;
   logic [NR_SIGNALS-1:0] prev_q, prev_d;

   logic [NR_SIGNALS-1:0] chg;
   logic                  qual;
   logic [NR_STAGES-1:0]  stage_hit;
   logic                  cur_hit;
   logic                  store;

   assign chg  = signals_in ^ prev_q;
   assign qual = store_always | (|(chg & store_mask));

   // Per-stage match: every masked signal at its level, and changed if edge-qualified.
   always_comb begin
      stage_hit = '0;
      for (int s = 0; s < NR_STAGES; s++) begin
         stage_hit[s] = &(~stage_mask[s*NR_SIGNALS +: NR_SIGNALS] |
                          (~(signals_in ^ stage_value[s*NR_SIGNALS +: NR_SIGNALS]) &
                           (~stage_edge[s*NR_SIGNALS +: NR_SIGNALS] | chg)));
      end
   end

   // Select the match result of the stage currently awaited.
   always_comb begin
      cur_hit = 1'b0;
      for (int s = 0; s < NR_STAGES; s++) begin
         if (cur_stage_q == STG_BITS'(s)) begin
            cur_hit = stage_hit[s];
         end
      end
   end

   // Next-state logic: FSM, stage sequencing, pointers and counters.
   always_comb begin
      state_d        = state_q;
      cur_stage_d    = cur_stage_q;
      triggered_d    = triggered_q;
      wrapped_d      = wrapped_q;
      wr_ptr_d       = wr_ptr_q;
      remain_d       = remain_q;
      trigger_addr_d = trigger_addr_q;
      stop_addr_d    = stop_addr_q;
      prev_d         = prev_q;
      store          = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start && !abort) begin
               state_d     = ST_ARMED;
               wr_ptr_d    = '0;
               cur_stage_d = '0;
               triggered_d = 1'b0;
               wrapped_d   = 1'b0;
               remain_d    = '0;
               prev_d      = signals_in;
            end
         end
         ST_ARMED: begin
            prev_d = signals_in;
            if (abort) begin
               state_d = ST_DONE;
            end else if (cur_hit && (cur_stage_q == stages_used)) begin
               store          = 1'b1;
               trigger_addr_d = wr_ptr_q;
               triggered_d    = 1'b1;
               remain_d       = post_trigger_count;
               state_d        = (post_trigger_count == '0) ? ST_DONE : ST_TRIGGERED;
            end else begin
               store = qual;
               if (cur_hit && (cur_stage_q < stages_used)) begin
                  cur_stage_d = cur_stage_q + STG_BITS'(1);
               end
            end
         end
         ST_TRIGGERED: begin
            prev_d = signals_in;
            if (abort) begin
               state_d = ST_DONE;
            end else if (qual) begin
               store    = 1'b1;
               remain_d = remain_q - ADDR_BITS'(1);
               if (remain_q == ADDR_BITS'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (store) begin
         stop_addr_d = wr_ptr_q;
         wr_ptr_d    = wr_ptr_q + ADDR_BITS'(1);
         if (wr_ptr_q == ADDR_BITS'(RECORD_DEPTH - 1)) begin
            wrapped_d = 1'b1;
         end
      end

      start_addr_d = wrapped_d ? (stop_addr_d + ADDR_BITS'(1)) : '0;
   end

   // State and pointer registers with synchronous reset.
   always_ff @(posedge src_clk) begin
      if (src_reset) begin
         state_q        <= ST_IDLE;
         cur_stage_q    <= '0;
         triggered_q    <= 1'b0;
         wrapped_q      <= 1'b0;
         wr_ptr_q       <= '0;
         remain_q       <= '0;
         start_addr_q   <= '0;
         trigger_addr_q <= '0;
         stop_addr_q    <= '0;
         prev_q         <= '0;
      end else begin
         state_q        <= state_d;
         cur_stage_q    <= cur_stage_d;
         triggered_q    <= triggered_d;
         wrapped_q      <= wrapped_d;
         wr_ptr_q       <= wr_ptr_d;
         remain_q       <= remain_d;
         start_addr_q   <= start_addr_d;
         trigger_addr_q <= trigger_addr_d;
         stop_addr_q    <= stop_addr_d;
         prev_q         <= prev_d;
      end
   end

   icetap_capture_ram #(
      .WIDTH (NR_SIGNALS),
      .DEPTH (RECORD_DEPTH)
   ) u_ram (
      .clk   (src_clk),
      .we    (store),
      .waddr (wr_ptr_q),
      .wdata (signals_in),
      .raddr (read_addr),
      .rdata (read_data)
   );

   assign state        = state_q;
   assign cur_stage    = cur_stage_q;
   assign triggered    = triggered_q;
   assign wrapped      = wrapped_q;
   assign start_addr   = start_addr_q;
   assign trigger_addr = trigger_addr_q;
   assign stop_addr    = stop_addr_q;

endmodule

// File: tb/tb_icetap_seq_capture.sv
// Directed bench for icetap_seq_capture (8 signals, depth 16, 4 stages).
module tb_icetap_seq_capture;

   localparam int NS = 8;
   localparam int RD = 16;
   localparam int NT = 4;
   localparam int AB = 4;
   localparam int SB = 2;

   logic          src_clk = 1'b0;
   logic          src_reset;
   logic [NS-1:0] signals_in;
   logic          start;
   logic          abort;
   logic [SB-1:0] stages_used;
   logic [NT*NS-1:0] stage_mask;
   logic [NT*NS-1:0] stage_value;
   logic [NT*NS-1:0] stage_edge;
   logic [NS-1:0] store_mask;
   logic          store_always;
   logic [AB-1:0] post_trigger_count;
   logic [1:0]    state;
   logic [SB-1:0] cur_stage;
   logic          triggered;
   logic          wrapped;
   logic [AB-1:0] start_addr;
   logic [AB-1:0] trigger_addr;
   logic [AB-1:0] stop_addr;
   logic [AB-1:0] read_addr;
   logic [NS-1:0] read_data;

   int total = 0;
   int bad   = 0;

   icetap_seq_capture #(
      .NR_SIGNALS   (NS),
      .RECORD_DEPTH (RD),
      .NR_STAGES    (NT)
   ) dut (
      .src_clk            (src_clk),
      .src_reset          (src_reset),
      .signals_in         (signals_in),
      .start              (start),
      .abort              (abort),
      .stages_used        (stages_used),
      .stage_mask         (stage_mask),
      .stage_value        (stage_value),
      .stage_edge         (stage_edge),
      .store_mask         (store_mask),
      .store_always       (store_always),
      .post_trigger_count (post_trigger_count),
      .state              (state),
      .cur_stage          (cur_stage),
      .triggered          (triggered),
      .wrapped            (wrapped),
      .start_addr         (start_addr),
      .trigger_addr       (trigger_addr),
      .stop_addr          (stop_addr),
      .read_addr          (read_addr),
      .read_data          (read_data)
   );

   // Clock.
   always #5 src_clk = ~src_clk;

   // Advance one active edge; outputs are then sampled 1 ns later.
   task automatic tick();
      @(posedge src_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Single stage matching 0xA5, counter stimulus from seed+1 up to 0xA5+ptc.
   task automatic capture_counter(input logic [7:0] seed, input int ptc);
      int nsamp;
      int exp_trig;
      int exp_stop;
      int exp_start;
      int n_pre;
      logic exp_wrap;
      stage_mask         = '0;
      stage_value        = '0;
      stage_edge         = '0;
      stage_mask[7:0]    = 8'hFF;
      stage_value[7:0]   = 8'hA5;
      stages_used        = 2'd0;
      store_always       = 1'b1;
      store_mask         = '0;
      post_trigger_count = AB'(ptc);
      signals_in         = seed;
      start              = 1'b1;
      tick();
      start = 1'b0;
      chk("cnt_armed", 32'(state), 32'd1);
      nsamp = 0;
      for (int v = int'(seed) + 1; v <= 'hA5 + ptc; v++) begin
         signals_in = 8'(v);
         tick();
         nsamp++;
         if (v == 'hA5) begin
            chk("cnt_trig_state", 32'(state), (ptc == 0) ? 32'd3 : 32'd2);
            chk("cnt_triggered", 32'(triggered), 32'd1);
         end
      end
      exp_trig  = ('hA5 - int'(seed) - 1) % RD;
      exp_stop  = (nsamp - 1) % RD;
      exp_wrap  = (nsamp >= RD);
      exp_start = exp_wrap ? (exp_stop + 1) % RD : 0;
      chk("cnt_done", 32'(state), 32'd3);
      chk("cnt_trig_addr", 32'(trigger_addr), 32'(exp_trig));
      chk("cnt_stop_addr", 32'(stop_addr), 32'(exp_stop));
      chk("cnt_wrapped", 32'(wrapped), 32'(exp_wrap));
      chk("cnt_start_addr", 32'(start_addr), 32'(exp_start));
      // Trigger sample and post-trigger samples.
      for (int k = 0; k <= ptc; k++) begin
         read_addr = AB'((exp_trig + k) % RD);
         tick();
         chk("cnt_rd_post", 32'(read_data), 32'('hA5 + k));
      end
      // Pre-trigger history from the oldest entry up to the trigger.
      n_pre = (exp_trig - exp_start + RD) % RD;
      for (int k = 0; k < n_pre; k++) begin
         read_addr = AB'((exp_start + k) % RD);
         tick();
         chk("cnt_rd_pre", 32'(read_data), 32'('hA5 - (n_pre - k)));
      end
   endtask

   initial begin
      int ntog;
      logic [7:0] sig;
      src_reset          = 1'b1;
      signals_in         = '0;
      start              = 1'b0;
      abort              = 1'b0;
      stages_used        = '0;
      stage_mask         = '0;
      stage_value        = '0;
      stage_edge         = '0;
      store_mask         = '0;
      store_always       = 1'b0;
      post_trigger_count = '0;
      read_addr          = '0;
      tick();
      tick();
      src_reset = 1'b0;

      // Reset values.
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_stage", 32'(cur_stage), 32'd0);
      chk("rst_trig", 32'(triggered), 32'd0);
      chk("rst_wrap", 32'(wrapped), 32'd0);
      chk("rst_start", 32'(start_addr), 32'd0);
      chk("rst_taddr", 32'(trigger_addr), 32'd0);
      chk("rst_stop", 32'(stop_addr), 32'd0);

      // Abort in IDLE has no effect.
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("idle_abort", 32'(state), 32'd0);

      // Basic capture without wrap, three post-trigger samples.
      capture_counter(8'h9A, 3);

      // Two-stage sequence: bit0 rising edge, then bit1 high.
      stage_mask         = '0;
      stage_value        = '0;
      stage_edge         = '0;
      stage_mask[7:0]    = 8'h01;
      stage_value[7:0]   = 8'h01;
      stage_edge[7:0]    = 8'h01;
      stage_mask[15:8]   = 8'h02;
      stage_value[15:8]  = 8'h02;
      stages_used        = 2'd1;
      store_always       = 1'b1;
      post_trigger_count = '0;
      signals_in         = 8'h00;
      start              = 1'b1;
      tick();
      start      = 1'b0;
      signals_in = 8'h02;
      tick();
      chk("seq_early_b1_stage", 32'(cur_stage), 32'd0);
      chk("seq_early_b1_state", 32'(state), 32'd1);
      signals_in = 8'h00;
      tick();
      signals_in = 8'h01;
      tick();
      chk("seq_edge_stage", 32'(cur_stage), 32'd1);
      chk("seq_edge_state", 32'(state), 32'd1);
      signals_in = 8'h01;
      tick();
      chk("seq_wait_stage", 32'(cur_stage), 32'd1);
      signals_in = 8'h03;
      tick();
      chk("seq_trig_state", 32'(state), 32'd3);
      chk("seq_triggered", 32'(triggered), 32'd1);
      chk("seq_trig_addr", 32'(trigger_addr), 32'd4);

      // Change-qualified storage on bit0 toggles; a start while armed is ignored.
      stage_mask         = '0;
      stage_value        = '0;
      stage_edge         = '0;
      stage_mask[7:0]    = 8'hFF;
      stage_value[7:0]   = 8'hFF;
      stages_used        = 2'd0;
      store_always       = 1'b0;
      store_mask         = 8'h01;
      signals_in         = 8'h00;
      start              = 1'b1;
      tick();
      start = 1'b0;
      ntog  = 0;
      for (int i = 1; i <= 12; i++) begin
         sig        = 8'((i / 3) % 2);
         start      = (i == 5);
         if (sig != signals_in) ntog++;
         signals_in = sig;
         tick();
         if (sig[0] == 1'b1 && i % 3 == 0 || sig[0] == 1'b0 && i % 6 == 0) begin
            chk("chg_stop", 32'(stop_addr), 32'(ntog - 1));
         end
      end
      start = 1'b0;
      chk("chg_ntog", 32'(ntog), 32'd4);
      chk("chg_state", 32'(state), 32'd1);
      chk("chg_stop_end", 32'(stop_addr), 32'd3);

      // Abort while armed, then start+abort together from DONE.
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_state", 32'(state), 32'd3);
      chk("abort_trig", 32'(triggered), 32'd0);
      chk("abort_stop", 32'(stop_addr), 32'd3);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_state", 32'(state), 32'd3);

      // Trigger after 40 samples: buffer wraps, 10 pre-trigger entries remain.
      capture_counter(8'h7D, 5);

      // Reset in the middle of a triggered capture.
      stage_mask         = '0;
      stage_value        = '0;
      stage_edge         = '0;
      stage_mask[7:0]    = 8'hFF;
      stage_value[7:0]   = 8'hA5;
      stages_used        = 2'd0;
      store_always       = 1'b1;
      post_trigger_count = 4'd15;
      signals_in         = 8'hA4;
      start              = 1'b1;
      tick();
      start      = 1'b0;
      signals_in = 8'hA5;
      tick();
      chk("mid_trig_state", 32'(state), 32'd2);
      signals_in = 8'h11;
      src_reset  = 1'b1;
      tick();
      src_reset = 1'b0;
      chk("mid_rst_state", 32'(state), 32'd0);
      chk("mid_rst_trig", 32'(triggered), 32'd0);
      chk("mid_rst_taddr", 32'(trigger_addr), 32'd0);
      chk("mid_rst_stop", 32'(stop_addr), 32'd0);
      chk("mid_rst_start", 32'(start_addr), 32'd0);
      chk("mid_rst_wrap", 32'(wrapped), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/icetap_seq_capture.md
# icetap_seq_capture

Single-clock capture core for the icetap logic analyser, successor to the fixed store/trigger BRAM recorder. Adds a parametrised multi-stage sequential trigger, a programmable post-trigger sample count over a circular buffer, change-qualified storage and an abort command. It sits in the `src_clk` domain behind the scan/JTAG configuration logic, which drives its configuration and command inputs and reads back status and recorded data.

## Interface
- `NR_SIGNALS`, 16: probed signal count, 1..64.
- `RECORD_DEPTH`, 256: buffer entries; power of 2, ≥4. `ADDR_BITS = $clog2(RECORD_DEPTH)`.
- `NR_STAGES`, 4: trigger stages, 1..8. `STG_BITS = max(1, $clog2(NR_STAGES))`.
- `src_clk`, in, 1: the single clock.
- `src_reset`, in, 1: synchronous, active-high reset.
- `signals_in`, in, `NR_SIGNALS`: probed signals, already synchronous to `src_clk`.
- `start`, in, 1: one-cycle arm pulse.
- `abort`, in, 1: one-cycle stop pulse.
- `stages_used`, in, `STG_BITS`: last active stage index (0 means one stage).
- `stage_mask`, in, `NR_STAGES*NR_SIGNALS`: stage s uses bits `[s*NR_SIGNALS +: NR_SIGNALS]`; 1 = signal participates.
- `stage_value`, in, `NR_STAGES*NR_SIGNALS`: required level per participating signal.
- `stage_edge`, in, `NR_STAGES*NR_SIGNALS`: 1 = the signal must also differ from the previous sample.
- `store_mask`, in, `NR_SIGNALS`: store a sample only when a masked signal changed.
- `store_always`, in, 1: store every cycle; overrides `store_mask`.
- `post_trigger_count`, in, `ADDR_BITS`: samples stored after the trigger sample.
- `state`, out, 2: 0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE.
- `cur_stage`, out, `STG_BITS`: stage currently awaited.
- `triggered`, out, 1: trigger occurred in the last run.
- `wrapped`, out, 1: buffer wrapped at least once.
- `start_addr`, `trigger_addr`, `stop_addr`, out, `ADDR_BITS` each: oldest valid entry, trigger entry, last written entry.
- `read_addr`, in, `ADDR_BITS`: readback address.
- `read_data`, out, `NR_SIGNALS`: RAM word at `read_addr`, 1-cycle latency.

## Operation
- Reset: `state`=IDLE. `cur_stage`, `triggered`, `wrapped` and all address outputs are 0. The write pointer is 0. RAM contents are undefined.
- IDLE/DONE + `start` → ARMED. This clears the write pointer, `cur_stage`, `triggered`, `wrapped` and the count, and loads `prev` with `signals_in`.
- `start` is ignored in ARMED and TRIGGERED.
- `abort` in ARMED/TRIGGERED → DONE. `stop_addr` = last written entry; `triggered` is unchanged.
- If `abort` and `start` arrive together, `abort` wins.
- `abort` in IDLE/DONE has no effect.
- Change: `chg = signals_in ^ prev`. `prev` updates every cycle while ARMED/TRIGGERED.
- Store qualifier: `store_always | |(chg & store_mask)`.
- Stage s match: for every masked bit, `signals_in == stage_value` and, if `stage_edge` is set, `chg` = 1.
- ARMED:
  - Store qualified samples circularly.
  - If stage `cur_stage` matches and `cur_stage` < `stages_used`, increment `cur_stage`. At most one stage advances per cycle.
  - If stage `cur_stage` matches and `cur_stage` == `stages_used`, this is the trigger:
    - The sample is stored regardless of the qualifier.
    - `trigger_addr` = its address; `triggered` = 1.
    - If `post_trigger_count` == 0, go to DONE; otherwise go to TRIGGERED with the remaining count = `post_trigger_count`.
- TRIGGERED: each stored sample decrements the remaining count. The store that makes it 0 moves to DONE.
- Every store updates `stop_addr` to the write address, then increments the pointer modulo `RECORD_DEPTH`.
- A store at address `RECORD_DEPTH-1` sets `wrapped`.
- `start_addr` is 0 while `wrapped` = 0; otherwise it is `stop_addr+1` (mod depth), registered.
- If the buffer fills before the trigger, the oldest data is overwritten. The pre-trigger depth is therefore `RECORD_DEPTH-1-post_trigger_count`, or less if not yet filled.
- Configuration inputs must be stable outside IDLE/DONE; they are not registered.

## Timing
- `start` high at edge N → `state`=ARMED after edge N. The first sample is evaluated in cycle N+1.
- Trigger sample in cycle T → `state` changes and `trigger_addr`/`triggered` are valid after edge T.
- All outputs are registered; there are no combinational paths from inputs to `state`/address outputs.
- `read_data` is valid 1 cycle after `read_addr`. Reads are defined only in IDLE/DONE.
- A write and a read of the same address in the same cycle returns the old data.
- `src_reset` mid-capture → IDLE on the next edge with all reset values, regardless of other inputs.

## Structure
- Shared package `icetap_pkg`: state encodings `ST_IDLE`/`ST_ARMED`/`ST_TRIGGERED`/`ST_DONE` and limits `MAX_STAGES`, `MAX_SIGNALS`.
- Sub-module `icetap_capture_ram`: simple dual-port, one write port and one registered read port, parameters `WIDTH` and `DEPTH`, inferable as iCE40 BRAM.
- Top contains the FSM, stage matcher, pointers and counters.

## Test plan
- `NR_SIGNALS`=8, depth 16. `store_always`=1, one stage matching value 0xA5, `post_trigger_count`=3, drive a counter with 0xA5 at cycle 20 → DONE after 4 stores; `trigger_addr`=stop−3 (mod 16); read back 0xA5..0xA8.
- Two stages: stage 0 = bit0 rising edge, stage 1 = bit1 high. Bit1 high before any bit0 edge → no trigger. Bit0 edge, then bit1 high two cycles later → trigger; `cur_stage` goes 0→1 and `triggered`=1.
- `store_mask`=0x01, `store_always`=0, bit0 toggles every 3 cycles → only toggle samples are stored; `stop_addr` advances once per toggle.
- Trigger after 40 samples with depth 16 and `post_trigger_count`=5 → `wrapped`=1; `start_addr`=`stop_addr`+1; 10 pre-trigger entries are intact.
- `abort` in ARMED → DONE with `triggered`=0. `start`+`abort` in the same cycle from DONE → stays DONE.
- `src_reset` during TRIGGERED → IDLE, all address outputs 0, `triggered`=0 next cycle.
